dff_bit_deserializer: RTL

- Sits directly downstream of the single-bit DFF stage and consumes its registered serial output stream.
- Hunts for a programmable sync word, then locks and packs each following WIDTH-bit group into a parallel word.
- Delivers words on a valid/ready interface, with a sticky overflow flag when the consumer stalls.

---
 rtl/dff_deser_pkg.sv | 22 ++
 rtl/dff_bit_deserializer_out_slot.sv | 73 +++++++
 rtl/dff_bit_deserializer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/dff_deser_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dff_deser_pkg                                                |
// | Description : Shared types and default constants for the bit deserializer. |
// |               deser_state_t : HUNT (searching for sync) / LOCKED (framing) |
// |               DESER_WIDTH   : default word width                           |
// |               DESER_SYNC    : default sync pattern                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package dff_deser_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } deser_state_t;

  localparam int                     DESER_WIDTH = 8;
  localparam logic [DESER_WIDTH-1:0] DESER_SYNC  = 8'hA5;

endpackage

`default_nettype wire

// File: rtl/dff_bit_deserializer_out_slot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : deser_out_slot                                               |
// | Description : Single-entry valid/ready holding register with a sticky      |
// |               overflow flag for words that arrive while the entry is full. |
// | Ports       : clk, rst        - clock, synchronous active-high reset       |
// |               clear           - drop the held word and clear overflow      |
// |               load, load_data - offer a newly completed word               |
// |               ready           - consumer accepts when valid & ready        |
// |               data, valid     - held word and its qualifier                |
// |               overflow        - sticky, a completed word was dropped       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module deser_out_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overflow
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             handshake;

  assign handshake = valid_q & ready;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (clear) begin
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end else if (load) begin
      // A word consumed in the same cycle frees the slot for the new one.
      if (!valid_q || handshake) begin
        data_d  = load_data;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (handshake) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data     = data_q;
  assign valid    = valid_q;
  assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: rtl/dff_bit_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dff_bit_deserializer                                         |
// | Description : Hunts a serial MSB-first stream for SYNC_WORD, then packs    |
// |               each following WIDTH-bit group into a parallel word held in  |
// |               a one-entry valid/ready slot.                                |
// | Ports       : clk, rst               - clock, sync active-high reset       |
// |               din, din_valid         - serial bit and its qualifier        |
// |               clear_lock             - drop lock, return to HUNT           |
// |               word_data, word_valid,                                       |
// |               word_ready             - output word handshake               |
// |               locked                 - high while LOCKED                   |
// |               overflow               - sticky dropped-word flag            |
// |               parity_err             - one-cycle bad-parity pulse          |
// |                                        (present with DESER_PARITY_EN)      |
// | Build macro : DESER_PARITY_EN - each locked word carries a trailing        |
// |               even-parity bit; failing words are dropped.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dff_bit_deserializer
  import dff_deser_pkg::*;
#(
  parameter int               WIDTH     = DESER_WIDTH,
  parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(DESER_SYNC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear_lock,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             locked,
  output logic             overflow
`ifdef DESER_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef DESER_PARITY_EN
  // Counter runs one step further to take the parity bit.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);
`else
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
`endif

  deser_state_t     state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] word_bits;
  logic             word_done;

`ifdef DESER_PARITY_EN
  logic parity_err_q, parity_err_d;
`else
  // The oldest shift-register bit only matters when a parity bit follows.
  logic sr_msb_unused;
  assign sr_msb_unused = sr_q[WIDTH-1];
`endif

  assign nxt = {sr_q[WIDTH-2:0], din};

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;
    word_bits = nxt;
`ifdef DESER_PARITY_EN
    parity_err_d = 1'b0;
`endif
    if (clear_lock) begin
      // Takes priority over a bit arriving in the same cycle.
      state_d = HUNT;
      sr_d    = '0;
      cnt_d   = '0;
    end else if (din_valid) begin
      sr_d = nxt;
      case (state_q)
        HUNT: begin
          if (nxt == SYNC_WORD) begin
            state_d = LOCKED;
            cnt_d   = '0;
          end
        end
        LOCKED: begin
          if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
`ifdef DESER_PARITY_EN
            // din is the parity bit; the data word is already in sr_q.
            word_bits = sr_q;
            if (^{sr_q, din}) begin
              parity_err_d = 1'b1;
            end else begin
              word_done = 1'b1;
            end
`else
            word_done = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      sr_q    <= '0;
      cnt_q   <= '0;
`ifdef DESER_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
`ifdef DESER_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign locked = (state_q == LOCKED);
`ifdef DESER_PARITY_EN
  assign parity_err = parity_err_q;
`endif

  deser_out_slot #(
    .WIDTH(WIDTH)
  ) u_out_slot (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear_lock),
    .load     (word_done),
    .load_data(word_bits),
    .ready    (word_ready),
    .data     (word_data),
    .valid    (word_valid),
    .overflow (overflow)
  );

endmodule

`default_nettype wire
